negate_accumulate: RTL and testbench
====================================

Name: negate_accumulate

Overview:
Signed add/subtract accumulator fed by 4-bit operands. Subtract operations take the two's complement of the operand, computed at accumulator width, before accumulating. Two-stage valid/ready pipeline: stage 1 conditions the operand, stage 2 accumulates and holds the result until it is consumed. Sits directly downstream of the 4-bit two's-complement unit and forms the running-sum datapath.

Parameters:
WIDTH, 4, operand width in bits, signed two's complement.
ACC_WIDTH, 8, accumulator width in bits, signed. Must be greater than WIDTH.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand transaction offered.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  signed operand.
in_sub  input  1  1 = subtract operand, 0 = add.
in_clr  input  1  1 = accumulate onto 0 instead of the current sum.
out_valid  output  1  result transaction offered.
out_ready  input  1  downstream accepts the result.
out_acc  output  ACC_WIDTH  accumulator value after the op carried by this result.
ovf  output  1  sticky signed-overflow flag.
op_count  output  8  number of ops accumulated since reset or since the last clr op; wraps at 255 to 0.

Behaviour:
- Reset: asserting rst_n low asynchronously clears all state. While reset is asserted: s1_valid=0, out_valid=0, out_acc=0, ovf=0, op_count=0, in_ready=1. Any in-flight ops are dropped with no output.
- Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
  - adv2 = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || adv2 (combinational)
  - in_data, in_sub and in_clr are sampled only on acceptance.
- Stage 1 (on accept):
  - ext = sign-extend in_data to ACC_WIDTH.
  - op = in_sub ? (~ext + 1) : ext.
  - Negation is done at ACC_WIDTH, so the most negative operand negates exactly: -8 becomes +8.
  - Register op and clr; set s1_valid.
  - s1_valid clears on adv2 unless a new op is accepted in the same cycle (full throughput).
- Stage 2 (on adv2):
  - base = clr ? 0 : out_acc.
  - sum = base + op, truncated to ACC_WIDTH (wrap-around).
  - out_acc <= sum; out_valid <= 1.
  - ovf <= (clr ? 0 : ovf) | signed_overflow, where signed_overflow = (sign(base) == sign(op)) && (sign(sum) != sign(base)).
  - op_count <= clr ? 1 : op_count + 1.
- out_valid clears on out_ready when no adv2 occurs in the same cycle.
- out_acc, ovf and op_count stay stable while out_valid && !out_ready.
- Latency: result appears 2 cycles after acceptance when unstalled; sustained throughput is 1 op per cycle.
- Ordering: exactly one output per accepted input, in acceptance order. No drops, no duplicates.
- Backpressure: with out_ready=0 the block holds at most 2 ops (one in stage 1, one in the output register); in_ready drops to 0 only when both are full.
- Simultaneous accept and adv2 in the same cycle are both legal and both take effect.
- The accumulator is the out_acc register; there is no hidden copy.

Test Plan:
1. Reset, then idle -> out_valid=0, out_acc=0x00, ovf=0, op_count=0, in_ready=1. Assert rst_n low mid-stream with s1_valid=1 -> all outputs clear immediately; no spurious result after release.
2. out_ready=1; back-to-back ops {clr,add 5}, {add 3}, {sub 2} -> out_acc 5, 8, 6 on three consecutive cycles starting 2 cycles after the first accept; op_count 1, 2, 3; ovf=0.
3. Most-negative operand: {clr,sub 4'b1000} -> out_acc=0x08 (+8), ovf=0. Then {sub 4'b1000} -> out_acc=0x10 (+16).
4. Overflow: {clr,add 7}, then 18 more {add 7} -> 19th result = 133 mod 256 = 0x85 (-123) with ovf=1. A following {add 0} keeps ovf=1. Then {clr,add 1} -> out_acc=0x01, ovf=0, op_count=1.
5. Backpressure: out_ready=0, offer {clr,add 1}, {add 2}, {add 3} on consecutive cycles -> the first two are accepted; in_ready=0 while the third is offered; out_acc holds 1. Raise out_ready -> outputs 1, 3, 6 in order and the third is accepted on the first adv2.
6. Random stream (1000 ops, random in_valid/out_ready) -> each output equals the reference model's wrapped sum; ovf and op_count match; output count equals accepted count.

Source files
------------

// File: rtl/negate_accumulate.sv
// ---------------------------------------------------------------------------
// negate_accumulate
//
// Signed add/subtract accumulator fed by narrow two's-complement operands.
// The block has two pipeline stages joined by valid/ready handshakes.
// Stage 1 sign-extends the operand and, for a subtract, negates it at full
// accumulator width.
// Stage 2 adds the conditioned operand onto the running sum, or onto zero for
// a clear op. It then holds the result until downstream consumes it.
//
// Parameters
//   WIDTH      operand width in bits (signed)
//   ACC_WIDTH  accumulator width in bits (signed), must exceed WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all state
//   in_valid   operand transaction offered
//   in_ready   block can accept an operand this cycle (combinational)
//   in_data    signed operand
//   in_sub     1 = subtract operand, 0 = add
//   in_clr     1 = accumulate onto zero instead of the current sum
//   out_valid  result transaction offered
//   out_ready  downstream accepts the result
//   out_acc    accumulator value after the op carried by this result
//   ovf        sticky signed-overflow flag, cleared by a clear op
//   op_count   ops accumulated since reset or the last clear op (wraps)
// ---------------------------------------------------------------------------
module negate_accumulate #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic                 in_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 ovf,
  output logic [7:0]           op_count
);

  localparam int EXT_BITS = ACC_WIDTH - WIDTH;

  logic                 s1_valid;
  logic [ACC_WIDTH-1:0] s1_op;
  logic                 s1_clr;

  logic                 accept;
  logic                 adv2;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] cond_op;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sign_ovf;

  // Stage 2 can take the stage-1 op whenever the output register is empty
  // or is being drained this cycle. Stage 1 can refill in the same cycle
  // it empties, which gives one op per cycle of throughput.
  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;

  // The operand is negated after sign extension, so the most negative
  // operand still has a representable negation (-8 becomes +8 for 4 bits).
  always_comb begin
    ext     = {{EXT_BITS{in_data[WIDTH-1]}}, in_data};
    cond_op = ext;
    if (in_sub) begin
      cond_op = ~ext + ACC_WIDTH'(1);
    end
  end

  // The sum wraps at accumulator width. Signed overflow occurs when both
  // addends have the same sign and the sum's sign differs from theirs.
  always_comb begin
    base     = s1_clr ? '0 : out_acc;
    sum      = base + s1_op;
    sign_ovf = (base[ACC_WIDTH-1] == s1_op[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
  end

  // Stage 1 register. A new acceptance takes priority over emptying,
  // because both can happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_clr   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= cond_op;
      s1_clr   <= in_clr;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register. out_acc is the accumulator itself, so a stalled
  // result also holds the running sum steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      ovf       <= 1'b0;
      op_count  <= 8'd0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out_acc   <= sum;
      ovf       <= (s1_clr ? 1'b0 : ovf) | sign_ovf;
      op_count  <= s1_clr ? 8'd1 : op_count + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_negate_accumulate.sv
// ---------------------------------------------------------------------------
// tb_negate_accumulate
//
// Directed bench for negate_accumulate.
// Each scenario task drives its own stimulus and checks results against
// hand-computed values. A final random stream is compared against a
// small behavioural reference model.
// ---------------------------------------------------------------------------
module tb_negate_accumulate;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sub;
  logic       in_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_acc;
  logic       ovf;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  negate_accumulate #(.WIDTH(4), .ACC_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic clr, input logic sub, input logic [3:0] d);
    in_valid = v;
    in_clr   = clr;
    in_sub   = sub;
    in_data  = d;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Send one op into an empty pipeline with out_ready high.
  // On return, the op's result is presented on the outputs.
  task automatic single_op(input logic clr, input logic sub, input logic [3:0] d);
    set_in(1'b1, clr, sub, d);
    tick;
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_sub    = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_acc !== 8'h00 || ovf !== 1'b0 ||
        op_count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_hold: got v=%b acc=%h ovf=%b cnt=%0d rdy=%b expected 0 00 0 0 1",
               out_valid, out_acc, ovf, op_count, in_ready);
    end
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_acc !== 8'h00 || op_count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: got v=%b acc=%h cnt=%0d rdy=%b expected 0 00 0 1",
               out_valid, out_acc, op_count, in_ready);
    end
    // Fill both stages under backpressure, then reset in mid-cycle.
    set_in(1'b1, 1'b1, 1'b0, 4'd3);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 4'd2);
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'h03 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_prefill: got v=%b acc=%h rdy=%b expected 1 03 0",
               out_valid, out_acc, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_acc !== 8'h00 || op_count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_async: got v=%b acc=%h cnt=%0d rdy=%b expected 0 00 0 1",
               out_valid, out_acc, op_count, in_ready);
    end
    tick;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_spurious: cycle %0d got out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 4'd5);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 4'd3);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready: got in_ready=%b expected 1", in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'd5 || op_count !== 8'd1 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got v=%b acc=%0d cnt=%0d ovf=%b expected 1 5 1 0",
               out_valid, out_acc, op_count, ovf);
    end
    set_in(1'b1, 1'b0, 1'b1, 4'd2);
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'd8 || op_count !== 8'd2 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got v=%b acc=%0d cnt=%0d ovf=%b expected 1 8 2 0",
               out_valid, out_acc, op_count, ovf);
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'd6 || op_count !== 8'd3 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_third: got v=%b acc=%0d cnt=%0d ovf=%b expected 1 6 3 0",
               out_valid, out_acc, op_count, ovf);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_acc !== 8'd6) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got v=%b acc=%0d expected 0 6", out_valid, out_acc);
    end
  endtask

  task automatic test_most_negative;
    out_ready = 1'b1;
    single_op(1'b1, 1'b1, 4'b1000);
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'h08 || ovf !== 1'b0 || op_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL neg8_first: got v=%b acc=%h ovf=%b cnt=%0d expected 1 08 0 1",
               out_valid, out_acc, ovf, op_count);
    end
    single_op(1'b0, 1'b1, 4'b1000);
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'h10 || ovf !== 1'b0 || op_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL neg8_second: got v=%b acc=%h ovf=%b cnt=%0d expected 1 10 0 2",
               out_valid, out_acc, ovf, op_count);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_acc;
    out_ready = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      single_op(k == 1, 1'b0, 4'd7);
      exp_acc = 8'(7 * k);
      checks++;
      if (out_valid !== 1'b1 || out_acc !== exp_acc || op_count !== 8'(k) || ovf !== 1'(k == 19)) begin
        errors++;
        $display("[TB] FAIL ovf_step%0d: got v=%b acc=%h cnt=%0d ovf=%b expected 1 %h %0d %b",
                 k, out_valid, out_acc, op_count, ovf, exp_acc, k, (k == 19));
      end
    end
    single_op(1'b0, 1'b0, 4'd0);
    checks++;
    if (out_acc !== 8'h85 || ovf !== 1'b1 || op_count !== 8'd20) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got acc=%h ovf=%b cnt=%0d expected 85 1 20",
               out_acc, ovf, op_count);
    end
    single_op(1'b1, 1'b0, 4'd1);
    checks++;
    if (out_acc !== 8'h01 || ovf !== 1'b0 || op_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got acc=%h ovf=%b cnt=%0d expected 01 0 1",
               out_acc, ovf, op_count);
    end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 4'd1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept1: got in_ready=%b expected 1", in_ready);
    end
    tick;
    set_in(1'b1, 1'b0, 1'b0, 4'd2);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept2: got in_ready=%b expected 1", in_ready);
    end
    tick;
    set_in(1'b1, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 8'd1 || op_count !== 8'd1) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got rdy=%b v=%b acc=%0d cnt=%0d expected 0 1 1 1",
                 i, in_ready, out_valid, out_acc, op_count);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got in_ready=%b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'd3 || op_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL bp_out2: got v=%b acc=%0d cnt=%0d expected 1 3 2", out_valid, out_acc, op_count);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 8'd6 || op_count !== 8'd3) begin
      errors++;
      $display("[TB] FAIL bp_out3: got v=%b acc=%0d cnt=%0d expected 1 6 3", out_valid, out_acc, op_count);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [7:0] q_acc[$];
    logic       q_ovf[$];
    logic [7:0] q_cnt[$];
    logic [7:0] e_acc;
    logic       e_ovf;
    logic [7:0] e_cnt;
    int accepted = 0;
    int consumed = 0;
    int cycles   = 0;
    int ref_acc  = 0;
    int ref_ovf  = 0;
    int ref_cnt  = 0;
    int opv;
    int full;
    apply_reset;
    while ((accepted < 1000 || q_acc.size() > 0) && cycles < 20000) begin
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom_range(0, 15));
      in_sub    = 1'($urandom_range(0, 1));
      in_clr    = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        consumed++;
        checks++;
        if (q_acc.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra_output: got acc=%h with no op pending expected none", out_acc);
        end else begin
          e_acc = q_acc.pop_front();
          e_ovf = q_ovf.pop_front();
          e_cnt = q_cnt.pop_front();
          if (out_acc !== e_acc || ovf !== e_ovf || op_count !== e_cnt) begin
            errors++;
            $display("[TB] FAIL rand_result%0d: got acc=%h ovf=%b cnt=%0d expected %h %b %0d",
                     consumed, out_acc, ovf, op_count, e_acc, e_ovf, e_cnt);
          end
        end
      end
      if (in_valid && in_ready) begin
        opv = int'($signed(in_data));
        if (in_sub) opv = -opv;
        full    = (in_clr ? 0 : ref_acc) + opv;
        ref_ovf = (in_clr ? 0 : ref_ovf) | ((full > 127 || full < -128) ? 1 : 0);
        ref_acc = int'($signed(8'(full)));
        ref_cnt = in_clr ? 1 : (ref_cnt + 1) % 256;
        q_acc.push_back(8'(ref_acc));
        q_ovf.push_back(1'(ref_ovf));
        q_cnt.push_back(8'(ref_cnt));
        accepted++;
      end
      tick;
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (cycles >= 20000) begin
      errors++;
      $display("[TB] FAIL rand_timeout: got %0d accepted %0d outputs after %0d cycles expected 1000 1000",
               accepted, consumed, cycles);
    end
    checks++;
    if (consumed != accepted) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d outputs expected %0d", consumed, accepted);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_most_negative;
    test_overflow;
    test_backpressure;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
